// File: rtl/sysid_boot_pkg.sv
// Shared types and constants for the system ID boot checker.
package sysid_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int   RETRY_W       = 4;

endpackage

// File: rtl/sysid_read_timer.sv
// Per-read stall counter; expired marks the stall cycle that reaches
// TIMEOUT_CYCLES, after which the count starts over.
module sysid_read_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = stall && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear || expired) begin
            cnt <= '0;
        end else if (stall) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system ID read/compare sequencer over Avalon-MM.
// Timestamp check is built when SYSID_CHECK_TIMESTAMP_EN is defined.
module sysid_boot_checker
    import sysid_boot_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter int          READ_LATENCY   = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               avm_address,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [31:0]        avm_readdata,
    output logic               busy,
    output logic               done,
    output logic               id_ok,
    output logic               ts_ok,
    output logic               error_timeout,
    output logic [RETRY_W-1:0] retry_count,
    output logic [31:0]        captured_id
);

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    state_t state_q, state_d;

    logic               auto_q, auto_d;
    logic [RETRY_W-1:0] tries_q, tries_d;
    logic               read_d, addr_d, busy_d, done_d;
    logic               id_ok_d, err_d;
    logic [RETRY_W-1:0] retry_d;
    logic [31:0]        cap_d;
    logic               take;
    logic               accept, stall, expired;

`ifdef SYSID_CHECK_TIMESTAMP_EN
    logic ts_ok_d;
`endif

    assign accept = avm_read && !avm_waitrequest;
    assign stall  = avm_read && avm_waitrequest;

    sysid_read_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (!stall),
        .stall  (stall),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        tries_d = tries_q;
        read_d  = avm_read;
        addr_d  = avm_address;
        done_d  = done;
        id_ok_d = id_ok;
        err_d   = error_timeout;
        retry_d = retry_count;
        cap_d   = captured_id;
        take    = 1'b0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
        ts_ok_d = ts_ok;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (auto_q || start) begin
                    state_d = RD_ID;
                    auto_d  = 1'b0;
                    tries_d = '0;
                    read_d  = 1'b1;
                    addr_d  = SYSID_ADDR_ID;
                    done_d  = 1'b0;
                    id_ok_d = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
                    ts_ok_d = 1'b0;
`endif
                end
            end
            RD_ID, RD_TS: begin
                if (accept && READ_LATENCY == 0) begin
                    take = 1'b1;
                end else if (accept) begin
                    state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
                    read_d  = 1'b0;
                end else if (expired) begin
                    // Strobe drops for one cycle, then the same read re-issues.
                    read_d = 1'b0;
                    if (tries_q < RETRY_W'(MAX_RETRIES)) begin
                        tries_d = tries_q + 1'b1;
                        retry_d = retry_count + 1'b1;
                    end else begin
                        state_d = DONE;
                        addr_d  = SYSID_ADDR_ID;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else if (!avm_read) begin
                    read_d = 1'b1;
                end
            end
            LAT_ID, LAT_TS: begin
                take = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            tries_d = '0;
            if (state_q == RD_ID || state_q == LAT_ID) begin
                cap_d   = avm_readdata;
                id_ok_d = (avm_readdata == EXPECTED_ID);
                if (TS_EN) begin
                    state_d = RD_TS;
                    read_d  = 1'b1;
                    addr_d  = SYSID_ADDR_TS;
                end else begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
`ifdef SYSID_CHECK_TIMESTAMP_EN
                ts_ok_d = (avm_readdata == EXPECTED_TS);
`endif
                state_d = DONE;
                read_d  = 1'b0;
                addr_d  = SYSID_ADDR_ID;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            auto_q        <= 1'b1;
            tries_q       <= '0;
            avm_read      <= 1'b0;
            avm_address   <= SYSID_ADDR_ID;
            busy          <= 1'b0;
            done          <= 1'b0;
            id_ok         <= 1'b0;
            error_timeout <= 1'b0;
            retry_count   <= '0;
            captured_id   <= '0;
        end else begin
            state_q       <= state_d;
            auto_q        <= auto_d;
            tries_q       <= tries_d;
            avm_read      <= read_d;
            avm_address   <= addr_d;
            busy          <= busy_d;
            done          <= done_d;
            id_ok         <= id_ok_d;
            error_timeout <= err_d;
            retry_count   <= retry_d;
            captured_id   <= cap_d;
        end
    end

`ifdef SYSID_CHECK_TIMESTAMP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_ok <= 1'b0;
        end else begin
            ts_ok <= ts_ok_d;
        end
    end
`else
    assign ts_ok = 1'b1;
`endif

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized self-checking bench for sysid_boot_checker: two instances
// (zero and one cycle read latency) against a cycle-count reference model.
module tb_sysid_boot_checker;

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    localparam logic [31:0] EID_A = 32'h0000_0000;
    localparam logic [31:0] ETS_A = 32'hA5A5_0F0F;
    localparam int          TO_A  = 255;
    localparam int          MR_A  = 3;
    localparam int          RL_A  = 0;
    localparam logic [31:0] EID_B = 32'h1BAD_B002;
    localparam logic [31:0] ETS_B = 32'h2024_0611;
    localparam int          TO_B  = 6;
    localparam int          MR_B  = 2;
    localparam int          RL_B  = 1;

    function automatic int tmo(int u);
        return (u == 0) ? TO_A : TO_B;
    endfunction
    function automatic int mr(int u);
        return (u == 0) ? MR_A : MR_B;
    endfunction
    function automatic int rl(int u);
        return (u == 0) ? RL_A : RL_B;
    endfunction
    function automatic logic [31:0] eid(int u);
        return (u == 0) ? EID_A : EID_B;
    endfunction
    function automatic logic [31:0] ets(int u);
        return (u == 0) ? ETS_A : ETS_B;
    endfunction

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset [2];
    logic        start [2];
    logic        rd    [2];
    logic        addr  [2];
    logic        wreq  [2];
    logic [31:0] rdata [2];
    logic        busy  [2];
    logic        done  [2];
    logic        id_ok [2];
    logic        ts_ok [2];
    logic        err   [2];
    logic [3:0]  rcnt  [2];
    logic [31:0] cap   [2];

    int unsigned s_len  [2][2];
    logic [31:0] s_data [2][2];
    int unsigned s_cnt  [2];
    int unsigned n_acc  [2][2];
    logic        s_clr  [2];
    logic        lat_v  [2];
    logic        lat_a  [2];
    logic [31:0] cap_m  [2];

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur;

    sysid_boot_checker #(
        .EXPECTED_ID(EID_A), .EXPECTED_TS(ETS_A),
        .TIMEOUT_CYCLES(TO_A), .MAX_RETRIES(MR_A), .READ_LATENCY(RL_A)
    ) u_a (
        .clock(clock), .reset(reset[0]), .start(start[0]),
        .avm_address(addr[0]), .avm_read(rd[0]),
        .avm_waitrequest(wreq[0]), .avm_readdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]),
        .ts_ok(ts_ok[0]), .error_timeout(err[0]),
        .retry_count(rcnt[0]), .captured_id(cap[0])
    );

    sysid_boot_checker #(
        .EXPECTED_ID(EID_B), .EXPECTED_TS(ETS_B),
        .TIMEOUT_CYCLES(TO_B), .MAX_RETRIES(MR_B), .READ_LATENCY(RL_B)
    ) u_b (
        .clock(clock), .reset(reset[1]), .start(start[1]),
        .avm_address(addr[1]), .avm_read(rd[1]),
        .avm_waitrequest(wreq[1]), .avm_readdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]),
        .ts_ok(ts_ok[1]), .error_timeout(err[1]),
        .retry_count(rcnt[1]), .captured_id(cap[1])
    );

    // Slave stalls the first s_len stalled cycles of each read; data is
    // only valid in the cycle the latency setting says it should be.
    always_comb begin
        for (int u = 0; u < 2; u++) begin
            wreq[u] = (s_cnt[u] < s_len[u][addr[u]]);
            if (rl(u) == 0)
                rdata[u] = (rd[u] && !wreq[u]) ? s_data[u][addr[u]] : 32'hDEAD_BEEF;
            else
                rdata[u] = lat_v[u] ? s_data[u][lat_a[u]] : 32'hDEAD_BEEF;
        end
    end

    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) begin
            lat_a[u] <= addr[u];
            if (s_clr[u]) begin
                s_cnt[u]    <= 0;
                lat_v[u]    <= 1'b0;
                n_acc[u][0] <= 0;
                n_acc[u][1] <= 0;
            end else begin
                lat_v[u] <= rd[u] && !wreq[u];
                if (rd[u] && wreq[u]) begin
                    s_cnt[u] <= s_cnt[u] + 1;
                end else if (rd[u]) begin
                    s_cnt[u] <= 0;
                    n_acc[u][addr[u]] <= n_acc[u][addr[u]] + 1;
                end
            end
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, want %0h", cur, tag, got, exp);
        end
    endtask

    // Called at a negedge; releases reset at a later negedge.
    task automatic do_reset(int u);
        reset[u] = 1'b1;
        s_clr[u] = 1'b1;
        @(negedge clock);
        check("rst_read", rd[u], 0);
        check("rst_addr", addr[u], 0);
        check("rst_busy", busy[u], 0);
        check("rst_done", done[u], 0);
        check("rst_idok", id_ok[u], 0);
        check("rst_tsok", ts_ok[u], TS_EN ? 0 : 1);
        check("rst_err", err[u], 0);
        check("rst_retry", rcnt[u], 0);
        check("rst_cap", cap[u], 0);
        cap_m[u] = 32'h0;
        reset[u] = 1'b0;
        s_clr[u] = 1'b0;
    endtask

    // The run's trigger has just been applied; the next edge starts it.
    task automatic run_check(int u, int pulse_at);
        int  c = 1;
        int  rt = 0;
        bit  er = 0;
        bit  iok = 0;
        bit  tok = !TS_EN;
        int  acc [2] = '{0, 0};
        int  cyc = 0;
        for (int i = 0; i < (TS_EN ? 2 : 1); i++) begin
            int s = int'(s_len[u][i]);
            int a = s / tmo(u);
            if (a > mr(u)) begin
                rt += mr(u);
                er = 1;
                c += (mr(u) + 1) * tmo(u) + mr(u);
                break;
            end
            rt += a;
            c += s + 1 + a + rl(u);
            acc[i] = 1;
            if (i == 0) begin
                cap_m[u] = s_data[u][0];
                iok = (s_data[u][0] == eid(u));
            end else begin
                tok = (s_data[u][1] == ets(u));
            end
        end
        do begin
            @(negedge clock);
            cyc++;
            start[u] = (cyc == pulse_at);
            if (cyc == 1) begin
                check("c1_read", rd[u], 1);
                check("c1_addr", addr[u], 0);
                check("c1_busy", busy[u], 1);
                check("c1_done", done[u], 0);
                check("c1_retry", rcnt[u], 0);
            end
        end while (!done[u] && cyc < c + 20);
        start[u] = 1'b0;
        check("done_cyc", cyc, c);
        check("retry", rcnt[u], rt);
        check("err", err[u], er);
        check("id_ok", id_ok[u], iok);
        check("ts_ok", ts_ok[u], tok);
        check("cap", cap[u], cap_m[u]);
        check("acc_id", n_acc[u][0], acc[0]);
        check("acc_ts", n_acc[u][1], acc[1]);
        repeat (2) @(negedge clock);
        check("hold_done", done[u], 1);
        check("hold_busy", busy[u], 0);
        check("hold_read", rd[u], 0);
    endtask

    task automatic start_run(int u, int pulse_at);
        @(negedge clock);
        s_clr[u] = 1'b1;
        @(negedge clock);
        s_clr[u] = 1'b0;
        start[u] = 1'b1;
        run_check(u, pulse_at);
    endtask

    task automatic set_slave(int u, int s0, int s1, logic [31:0] d0, logic [31:0] d1);
        s_len[u][0]  = s0;
        s_len[u][1]  = s1;
        s_data[u][0] = d0;
        s_data[u][1] = d1;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            reset[u] = 1'b1;
            start[u] = 1'b0;
            s_clr[u] = 1'b1;
            cap_m[u] = 32'h0;
            set_slave(u, 0, 0, eid(u), ets(u));
        end
        @(negedge clock);

        cur = "a_boot";
        do_reset(0);
        run_check(0, 0);

        cur = "a_mismatch";
        set_slave(0, 0, 0, 32'h1234_5678, ETS_A);
        start_run(0, 0);

        cur = "a_retry1";
        set_slave(0, 300, 0, EID_A, 32'h0BAD_0000);
        start_run(0, 0);

        cur = "a_stuck";
        set_slave(0, 100000, 100000, EID_A, ETS_A);
        start_run(0, 0);

        cur = "a_abort";
        set_slave(0, TS_EN ? 0 : 100, 100, EID_A, ETS_A);
        start_run(0, 0);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        repeat (7) @(negedge clock);
        check("mid_read", rd[0], 1);
        check("mid_addr", addr[0], TS_EN);
        check("mid_busy", busy[0], 1);
        set_slave(0, 2, 3, 32'h0000_0042, ETS_A);
        do_reset(0);
        run_check(0, 2);

        for (int k = 0; k < 6; k++) begin
            int s0 = ($urandom_range(0, 2) == 0) ? $urandom_range(250, 1100) : $urandom_range(0, 8);
            int s1 = ($urandom_range(0, 2) == 0) ? $urandom_range(250, 1100) : $urandom_range(0, 8);
            cur = $sformatf("a_rand%0d", k);
            set_slave(0, s0, s1,
                      $urandom_range(0, 1) ? EID_A : $urandom(),
                      $urandom_range(0, 1) ? ETS_A : $urandom());
            start_run(0, (k == 2) ? 3 : 0);
        end

        cur = "b_boot";
        set_slave(1, 0, 0, EID_B, ETS_B);
        @(negedge clock);
        do_reset(1);
        run_check(1, 0);

        for (int k = 0; k < 24; k++) begin
            cur = $sformatf("b_rand%0d", k);
            set_slave(1, $urandom_range(0, 22), $urandom_range(0, 22),
                      $urandom_range(0, 1) ? EID_B : $urandom(),
                      $urandom_range(0, 1) ? ETS_B : $urandom());
            start_run(1, (k % 5 == 1) ? 2 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
